// File: rtl/ps2_note_decoder.sv
// ----------------------------------------------------------------------------
// ps2_note_decoder
//   Receives device-to-host PS/2 keyboard frames, extracts the scancode bytes,
//   follows make / break (F0) / extended (E0) sequences, and maps the three
//   letter rows of the keyboard onto note indices 1..21 for the piano
//   controller. STOP_CODE on the output means no note is held.
//
// Ports
//   iClk       system clock
//   iReset_n   asynchronous active-low reset
//   iPs2_Clk   raw PS/2 clock line (asynchronous, synchronised here)
//   iPs2_Dat   raw PS/2 data line  (asynchronous, synchronised here)
//   oPs2_Data  current note code: 1..21, or STOP_CODE
//   oValid     one-cycle pulse whenever oPs2_Data changes value
//   oFrameErr  one-cycle pulse whenever a frame is discarded
//
// Configuration macro
//   PARITY_CHECK_EN  when defined, frames failing odd parity are dropped and
//                    flagged on oFrameErr; otherwise the parity bit is ignored.
// ----------------------------------------------------------------------------
module ps2_note_decoder #(
    parameter int         FILTER_LEN     = 4,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] STOP_CODE      = 8'd99
) (
    input  logic       iClk,
    input  logic       iReset_n,
    input  logic       iPs2_Clk,
    input  logic       iPs2_Dat,
    output logic [7:0] oPs2_Data,
    output logic       oValid,
    output logic       oFrameErr
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
    typedef enum logic [1:0] {D_MAKE, D_BRK, D_EXT, D_EXT_BRK} dec_state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_q;
    logic          filt_prev_q;
    logic          fall;
    logic          dat;

    assign dat  = dat_sync_q[1];
    // Falling edge is seen the cycle after the filtered level drops.
    assign fall = filt_prev_q & ~filt_q;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            filt_cnt_q  <= '0;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], iPs2_Clk};
            dat_sync_q  <= {dat_sync_q[0], iPs2_Dat};
            filt_prev_q <= filt_q;
            // Count consecutive samples that disagree with the filtered level;
            // flip only once FILTER_LEN of them have been seen in a row.
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_MAX) begin
                filt_cnt_q <= '0;
                filt_q     <= clk_sync_q[1];
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    frame_state_t  fstate_q, fstate_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          byte_stb_q, byte_stb_d;
    logic          ferr_q, ferr_d;
    logic          par_ok;

`ifdef PARITY_CHECK_EN
    // Odd parity: XOR over data and parity bit must be 1.
    assign par_ok = par_q;
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            fstate_q   <= F_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_stb_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            fstate_q   <= fstate_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_stb_q <= byte_stb_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        fstate_d   = fstate_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        to_cnt_d   = to_cnt_q;
        byte_stb_d = 1'b0;
        ferr_d     = 1'b0;

        if (fstate_q == F_IDLE) begin
            to_cnt_d = '0;
            if (fall && !dat) begin
                fstate_d  = F_DATA;
                bit_cnt_d = '0;
                par_d     = 1'b0;
            end
        end else if (fall) begin
            to_cnt_d = '0;
            case (fstate_q)
                F_DATA: begin
                    shift_d = {dat, shift_q[7:1]};
                    par_d   = par_q ^ dat;
                    if (bit_cnt_q == 3'd7) begin
                        fstate_d = F_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                F_PARITY: begin
                    par_d    = par_q ^ dat;
                    fstate_d = F_STOP;
                end
                default: begin
                    fstate_d = F_IDLE;
                    if (dat && par_ok) begin
                        byte_stb_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            endcase
        end else if (to_cnt_q == TO_MAX) begin
            fstate_d = F_IDLE;
            to_cnt_d = '0;
            ferr_d   = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scancode -> note map (0 = unmapped)
    // ------------------------------------------------------------------
    logic [7:0] mapped_note;

    always_comb begin
        case (shift_q)
            8'h1C: mapped_note = 8'd1;
            8'h1B: mapped_note = 8'd2;
            8'h23: mapped_note = 8'd3;
            8'h2B: mapped_note = 8'd4;
            8'h34: mapped_note = 8'd5;
            8'h33: mapped_note = 8'd6;
            8'h3B: mapped_note = 8'd7;
            8'h15: mapped_note = 8'd8;
            8'h1D: mapped_note = 8'd9;
            8'h24: mapped_note = 8'd10;
            8'h2D: mapped_note = 8'd11;
            8'h2C: mapped_note = 8'd12;
            8'h35: mapped_note = 8'd13;
            8'h3C: mapped_note = 8'd14;
            8'h1A: mapped_note = 8'd15;
            8'h22: mapped_note = 8'd16;
            8'h21: mapped_note = 8'd17;
            8'h2A: mapped_note = 8'd18;
            8'h32: mapped_note = 8'd19;
            8'h31: mapped_note = 8'd20;
            8'h3A: mapped_note = 8'd21;
            default: mapped_note = 8'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Decoder FSM and output registers
    // ------------------------------------------------------------------
    dec_state_t dstate_q, dstate_d;
    logic [7:0] note_q, note_d;
    logic       valid_q, valid_d;
    logic       err_out_q;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            dstate_q  <= D_MAKE;
            note_q    <= STOP_CODE;
            valid_q   <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            dstate_q  <= dstate_d;
            note_q    <= note_d;
            valid_q   <= valid_d;
            // Delayed one stage so it lines up with oValid timing; since one
            // frame event yields either a byte or an error, they never overlap.
            err_out_q <= ferr_q;
        end
    end

    always_comb begin
        dstate_d = dstate_q;
        note_d   = note_q;
        valid_d  = 1'b0;

        if (byte_stb_q) begin
            case (dstate_q)
                D_MAKE: begin
                    if (shift_q == 8'hF0) begin
                        dstate_d = D_BRK;
                    end else if (shift_q == 8'hE0) begin
                        dstate_d = D_EXT;
                    end else if (mapped_note != 8'd0 && mapped_note != note_q) begin
                        // Last key wins; a typematic repeat changes nothing.
                        note_d  = mapped_note;
                        valid_d = 1'b1;
                    end
                end
                D_BRK: begin
                    dstate_d = D_MAKE;
                    if (mapped_note != 8'd0 && mapped_note == note_q) begin
                        note_d  = STOP_CODE;
                        valid_d = 1'b1;
                    end
                end
                D_EXT: begin
                    dstate_d = (shift_q == 8'hF0) ? D_EXT_BRK : D_MAKE;
                end
                default: begin
                    dstate_d = D_MAKE;
                end
            endcase
        end
    end

    assign oPs2_Data = note_q;
    assign oValid    = valid_q;
    assign oFrameErr = err_out_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
module tb_ps2_note_decoder;

    localparam int TO = 300;

    logic       iClk = 1'b0;
    logic       iReset_n = 1'b0;
    logic       iPs2_Clk = 1'b1;
    logic       iPs2_Dat = 1'b1;
    logic [7:0] oPs2_Data;
    logic       oValid;
    logic       oFrameErr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int last_valid_cyc = 0;
    int stop_cyc = 0;
    int v0;
    int e0;

    ps2_note_decoder #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(TO),
        .STOP_CODE     (8'd99)
    ) dut (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .iPs2_Clk (iPs2_Clk),
        .iPs2_Dat (iPs2_Dat),
        .oPs2_Data(oPs2_Data),
        .oValid   (oValid),
        .oFrameErr(oFrameErr)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (iReset_n) begin
            if (oValid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
            end
            if (oFrameErr) err_cnt++;
            if (oValid && oFrameErr) overlap_cnt++;
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iPs2_Clk = 1'b1;
        iPs2_Dat = 1'b1;
        iReset_n = 1'b0;
        repeat (3) @(negedge iClk);
        iReset_n = 1'b1;
        repeat (5) @(negedge iClk);
    endtask

    // One PS/2 bit: data set while clock high, then a 20-cycle low phase.
    task automatic send_bit(input logic b, input bit is_stop);
        iPs2_Dat = b;
        repeat (10) @(negedge iClk);
        iPs2_Clk = 1'b0;
        if (is_stop) stop_cyc = cyc;
        repeat (20) @(negedge iClk);
        iPs2_Clk = 1'b1;
        repeat (10) @(negedge iClk);
    endtask

    // nbits < 11 truncates the frame after that many bits.
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        @(negedge iClk);
        for (int i = 0; i < nbits; i++) send_bit(bits[i], i == 10);
        iPs2_Dat = 1'b1;
        repeat (30) @(negedge iClk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    initial begin
        do_reset();
        check_val("rst_data", int'(oPs2_Data), 99);
        check_val("rst_valid", int'(oValid), 0);
        check_val("rst_err", int'(oFrameErr), 0);

        // 1: single make code
        do_reset();
        v0 = valid_cnt;
        send_byte(8'h1C);
        check_val("t1_data", int'(oPs2_Data), 1);
        check_val("t1_pulses", valid_cnt - v0, 1);
        check_val("t1_latency", last_valid_cyc - stop_cyc, 8);

        // 2: make, break
        do_reset();
        v0 = valid_cnt;
        send_byte(8'h1C);
        check_val("t2_make", int'(oPs2_Data), 1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_val("t2_break", int'(oPs2_Data), 99);
        check_val("t2_pulses", valid_cnt - v0, 2);

        // 3: typematic, last key wins, stale break ignored
        do_reset();
        v0 = valid_cnt;
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        check_val("t3_typ_data", int'(oPs2_Data), 1);
        check_val("t3_typ_pulses", valid_cnt - v0, 1);
        send_byte(8'h15);
        check_val("t3_q_data", int'(oPs2_Data), 8);
        check_val("t3_q_pulses", valid_cnt - v0, 2);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_val("t3_stale_brk", int'(oPs2_Data), 8);
        check_val("t3_stale_pulses", valid_cnt - v0, 2);

        // 4: extended and unmapped codes ignored
        do_reset();
        v0 = valid_cnt;
        send_byte(8'hE0);
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h76);
        check_val("t4_data", int'(oPs2_Data), 99);
        check_val("t4_pulses", valid_cnt - v0, 0);

        // 5: timeout after 4 data bits, then recovery
        do_reset();
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 5);
        repeat (TO + 40) @(negedge iClk);
        check_val("t5_to_err", err_cnt - e0, 1);
        check_val("t5_to_data", int'(oPs2_Data), 99);
        send_byte(8'h2B);
        check_val("t5_rec_data", int'(oPs2_Data), 4);
        check_val("t5_rec_err", err_cnt - e0, 1);

        // 6: bad parity
        e0 = err_cnt;
        send_frame(8'h23, 1'b1, 1'b0, 11);
`ifdef PARITY_CHECK_EN
        check_val("t6_par_data", int'(oPs2_Data), 4);
        check_val("t6_par_err", err_cnt - e0, 1);
`else
        check_val("t6_par_data", int'(oPs2_Data), 3);
        check_val("t6_par_err", err_cnt - e0, 0);
`endif

        // 7: bad stop bit drops the byte
        e0 = err_cnt;
        v0 = valid_cnt;
        send_frame(8'h1A, 1'b0, 1'b1, 11);
        check_val("t7_stop_err", err_cnt - e0, 1);
        check_val("t7_stop_pulses", valid_cnt - v0, 0);

        // 8: reset mid-frame
        do_reset();
        send_byte(8'h1C);
        check_val("t8_pre", int'(oPs2_Data), 1);
        send_frame(8'h15, 1'b0, 1'b0, 6);
        do_reset();
        check_val("t8_rst_data", int'(oPs2_Data), 99);
        send_byte(8'h15);
        check_val("t8_post", int'(oPs2_Data), 8);

        check_val("overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
